// File: rtl/lia_phase_diff_averager.sv
// Pairs CH1/CH2 lock-in phase results, forms the wrapped difference and averages
// 2^AVG_LOG2 of them, unwrapped about the first sample of each block.

module lia_pda_chan #(
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clear,
  input  logic          i_valid,
  input  logic [PW-1:0] i_phase,
  input  logic          i_take,
  input  logic          i_drop,
  output logic          o_pend,
  output logic [PW-1:0] o_phase,
  output logic          o_overrun
);
  logic          r_pend;
  logic [PW-1:0] r_phase;

  // A strobe on the consuming cycle re-arms the slot instead of overrunning it.
  assign o_overrun = i_valid & r_pend & ~i_take & ~i_clear;
  assign o_pend    = r_pend;
  assign o_phase   = r_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend  <= 1'b0;
      r_phase <= '0;
    end else if (i_clear) begin
      r_pend  <= 1'b0;
    end else if (i_valid) begin
      r_pend  <= 1'b1;
      r_phase <= i_phase;
    end else if (i_take || i_drop) begin
      r_pend  <= 1'b0;
    end
  end
endmodule

module lia_phase_diff_averager #(
  parameter int PHASE_WIDTH    = 16,
  parameter int AVG_LOG2       = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic [PHASE_WIDTH-1:0] ch1_phase,
  input  logic                   ch1_valid,
  input  logic                   ch1_locked,
  input  logic [PHASE_WIDTH-1:0] ch2_phase,
  input  logic                   ch2_valid,
  input  logic                   ch2_locked,
  output logic [PHASE_WIDTH-1:0] phase_diff,
  output logic                   phase_diff_valid,
  output logic                   busy,
  output logic                   unlock_abort,
  output logic                   pair_overrun,
  output logic                   pair_timeout
);
  localparam int PW    = PHASE_WIDTH;
  localparam int ACC_W = PW + AVG_LOG2;
  localparam int NW    = AVG_LOG2 + 1;
  localparam int TCW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HALF  = (1 << AVG_LOG2) >> 1;
  localparam logic [NW-1:0]  N_LAST = NW'((1 << AVG_LOG2) - 1);
  localparam logic [TCW-1:0] T_LAST = TCW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t                   r_state;
  logic [PW-1:0]            r_ref;
  logic signed [ACC_W-1:0]  r_acc;
  logic [NW-1:0]            r_n;
  logic [TCW-1:0]           r_tcnt;

  logic [1:0]               w_valid, w_pend, w_ovr, w_drop;
  logic [1:0][PW-1:0]       w_phase_in, w_phase_q;
  logic                     w_take, w_lock, w_one, w_to;
  logic [PW-1:0]            w_d, w_delta, w_avg_out;
  logic signed [ACC_W-1:0]  w_delta_x;
  logic signed [ACC_W:0]    w_sum, w_shift;

  assign w_valid    = {ch2_valid, ch1_valid};
  assign w_phase_in = {ch2_phase, ch1_phase};

  for (genvar g = 0; g < 2; g++) begin : g_chan
    assign w_drop[g] = w_to & w_pend[g];
    lia_pda_chan #(.PW(PW)) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clear   (clear),
      .i_valid   (w_valid[g]),
      .i_phase   (w_phase_in[g]),
      .i_take    (w_take),
      .i_drop    (w_drop[g]),
      .o_pend    (w_pend[g]),
      .o_phase   (w_phase_q[g]),
      .o_overrun (w_ovr[g])
    );
  end

  // Pairs wait while the result is being published.
  assign w_take = w_pend[0] & w_pend[1] & (r_state != S_DONE) & ~clear;
  assign w_lock = ch1_locked & ch2_locked;
  assign w_one  = w_pend[0] ^ w_pend[1];
  assign w_to   = w_one & (r_tcnt == T_LAST) & ~clear;

  assign w_d       = w_phase_q[0] - w_phase_q[1];
  assign w_delta   = w_d - r_ref;
  assign w_delta_x = ACC_W'($signed(w_delta));
  assign w_sum     = (ACC_W+1)'(r_acc) + (ACC_W+1)'(HALF);
  assign w_shift   = w_sum >>> AVG_LOG2;
  assign w_avg_out = r_ref + w_shift[PW-1:0];

  assign busy = (r_state == S_ACCUM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tcnt <= '0;
    end else if (clear || !w_one || w_to) begin
      r_tcnt <= '0;
    end else begin
      r_tcnt <= r_tcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_overrun <= 1'b0;
      pair_timeout <= 1'b0;
    end else if (clear) begin
      pair_overrun <= 1'b0;
      pair_timeout <= 1'b0;
    end else begin
      if (|w_ovr) pair_overrun <= 1'b1;
      if (w_to)   pair_timeout <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_ref            <= '0;
      r_acc            <= '0;
      r_n              <= '0;
      phase_diff       <= '0;
      phase_diff_valid <= 1'b0;
      unlock_abort     <= 1'b0;
    end else begin
      phase_diff_valid <= 1'b0;
      unlock_abort     <= 1'b0;
      if (clear) begin
        r_state <= S_IDLE;
        r_acc   <= '0;
        r_n     <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_take && w_lock) begin
              r_ref   <= w_d;
              r_acc   <= '0;
              r_n     <= NW'(1);
              r_state <= (AVG_LOG2 == 0) ? S_DONE : S_ACCUM;
            end
          end
          S_ACCUM: begin
            if (w_take) begin
              if (w_lock) begin
                r_acc <= r_acc + w_delta_x;
                r_n   <= r_n + 1'b1;
                if (r_n == N_LAST) r_state <= S_DONE;
              end else begin
                unlock_abort <= 1'b1;
                r_state      <= S_IDLE;
              end
            end
          end
          S_DONE: begin
            phase_diff       <= w_avg_out;
            phase_diff_valid <= 1'b1;
            r_state          <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_lia_phase_diff_averager.sv
// Randomized self-checking bench for lia_phase_diff_averager against a
// queue-based averaging model.

module tb_lia_phase_diff_averager;
  localparam int PW = 16, AL = 4, TO = 100, NB = 16;

  logic          clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
  logic [PW-1:0] ch1_phase = '0, ch2_phase = '0;
  logic          ch1_valid = 1'b0, ch2_valid = 1'b0;
  logic          ch1_locked = 1'b1, ch2_locked = 1'b1;
  logic [PW-1:0] phase_diff;
  logic          phase_diff_valid, busy, unlock_abort, pair_overrun, pair_timeout;

  lia_phase_diff_averager #(.PHASE_WIDTH(PW), .AVG_LOG2(AL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .ch1_phase(ch1_phase), .ch1_valid(ch1_valid), .ch1_locked(ch1_locked),
    .ch2_phase(ch2_phase), .ch2_valid(ch2_valid), .ch2_locked(ch2_locked),
    .phase_diff(phase_diff), .phase_diff_valid(phase_diff_valid), .busy(busy),
    .unlock_abort(unlock_abort), .pair_overrun(pair_overrun), .pair_timeout(pair_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vld = 0, n_abort = 0, vld_cyc = 0, last_form = 0;
  logic [PW-1:0] last_pd = '0;
  always @(negedge clk) begin
    if (phase_diff_valid) begin
      n_vld++;
      last_pd = phase_diff;
      vld_cyc = cyc;
    end
    if (unlock_abort) n_abort++;
  end

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: list of locked differences in the current block.
  int q[$];
  function automatic int model_avg();
    int rf, sum, dd, r, avg;
    rf = q[0];
    sum = 0;
    foreach (q[i]) begin
      dd = (q[i] - rf + 65536) % 65536;
      if (dd >= 32768) dd -= 65536;
      sum += dd;
    end
    r = sum + NB / 2;
    avg = (r >= 0) ? r / NB : -((-r + NB - 1) / NB);
    return (rf + avg + 4 * 65536) % 65536;
  endfunction

  task automatic send_pair(input logic [PW-1:0] p1, input logic [PW-1:0] p2,
                           input int lag, input logic lk2);
    ch2_locked = lk2;
    @(negedge clk);
    ch1_valid = 1'b1; ch1_phase = p1;
    if (lag == 0) begin
      ch2_valid = 1'b1; ch2_phase = p2; last_form = cyc + 1;
    end
    @(negedge clk);
    ch1_valid = 1'b0; ch2_valid = 1'b0;
    if (lag > 0) begin
      repeat (lag - 1) @(negedge clk);
      ch2_valid = 1'b1; ch2_phase = p2; last_form = cyc + 1;
      @(negedge clk);
      ch2_valid = 1'b0;
    end
    repeat (3) @(negedge clk);
    ch2_locked = 1'b1;
    if (lk2) q.push_back((int'(p1) - int'(p2) + 65536) % 65536);
  endtask

  logic [PW-1:0] p1a [NB], p2a [NB];

  task automatic do_block(input string tag, input int lag, input bit rnd);
    int v0;
    v0 = n_vld;
    q.delete();
    for (int i = 0; i < NB; i++) begin
      send_pair(p1a[i], p2a[i], rnd ? int'($urandom_range(0, 3)) : lag, 1'b1);
      if (i == 7) chk({tag, "_busy"}, busy, 1);
    end
    repeat (4) @(negedge clk);
    chk({tag, "_cnt"}, n_vld, v0 + 1);
    chk({tag, "_val"}, last_pd, model_avg());
    chk({tag, "_lat"}, vld_cyc - last_form, 2);
    chk({tag, "_idle"}, busy, 0);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < NB; i++) begin
      p1a[i] = PW'($urandom);
      p2a[i] = PW'($urandom);
    end
  endtask

  logic [PW-1:0] saved;
  int v0, a0, c0, k;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_pd", phase_diff, 0);
    chk("rst_vld", phase_diff_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_abort", unlock_abort, 0);
    chk("rst_flags", {pair_overrun, pair_timeout}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Constant difference
    for (int i = 0; i < NB; i++) begin p1a[i] = 16'h4000; p2a[i] = 16'h2000; end
    do_block("t1", 0, 0);
    chk("t1_const", last_pd, 16'h2000);

    // Averaging across the +/-180 seam
    for (int i = 0; i < NB; i++) begin p1a[i] = i[0] ? 16'h8010 : 16'h7FF0; p2a[i] = 16'h0000; end
    do_block("t2", 0, 0);
    chk("t2_seam", last_pd, 16'h8000);

    // Same-cycle vs lagging ch2, then random lags
    fill_rand();
    do_block("t3a", 0, 0);
    saved = last_pd;
    do_block("t3b", 3, 0);
    chk("t3_same", last_pd, saved);
    for (int b = 0; b < 3; b++) begin
      fill_rand();
      do_block("t3r", 0, 1);
    end

    // Unlocked pair in IDLE is dropped silently
    a0 = n_abort; v0 = n_vld;
    send_pair(16'h1234, 16'h0234, 0, 1'b0);
    chk("t4_idle_abort", n_abort, a0);
    chk("t4_idle_busy", busy, 0);

    // Lock loss on pair 5
    fill_rand();
    q.delete();
    for (int i = 0; i < 4; i++) send_pair(p1a[i], p2a[i], 0, 1'b1);
    chk("t4_busy_pre", busy, 1);
    send_pair(p1a[4], p2a[4], 0, 1'b0);
    chk("t4_abort", n_abort, a0 + 1);
    chk("t4_busy_fall", busy, 0);
    chk("t4_novld", n_vld, v0);
    do_block("t4_next", 0, 1);

    // Timeout and overrun
    chk("t5_to_pre", pair_timeout, 0);
    @(negedge clk);
    ch1_valid = 1'b1; ch1_phase = 16'h1111; c0 = cyc;
    @(negedge clk);
    ch1_valid = 1'b0;
    for (k = 0; k < 300 && !pair_timeout; k++) @(negedge clk);
    chk("t5_to_set", pair_timeout, 1);
    chk("t5_to_lat", cyc - (c0 + 1), TO);
    chk("t5_ov_pre", pair_overrun, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); ch1_valid = 1'b1;
      @(negedge clk); ch1_valid = 1'b0;
    end
    @(negedge clk);
    chk("t5_ov_set", pair_overrun, 1);
    chk("t5_to_sticky", pair_timeout, 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("t5_clr_flags", {pair_overrun, pair_timeout}, 0);

    // clear mid-block
    fill_rand();
    saved = last_pd; v0 = n_vld;
    for (int i = 0; i < 10; i++) send_pair(p1a[i], p2a[i], 0, 1'b1);
    chk("t6_busy", busy, 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    chk("t6_clr_busy", busy, 0);
    chk("t6_clr_hold", phase_diff, saved);
    chk("t6_clr_novld", n_vld, v0);
    fill_rand();
    do_block("t6_after_clr", 0, 1);

    // reset mid-block
    fill_rand();
    for (int i = 0; i < 10; i++) send_pair(p1a[i], p2a[i], 0, 1'b1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_rst_pd", phase_diff, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_flags", {pair_overrun, pair_timeout, unlock_abort, phase_diff_valid}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    fill_rand();
    do_block("t6_after_rst", 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
